// File: rtl/result_sram_reader.sv
// result_sram_reader: reads result rows from SRAM and streams them out
// one element per handshake, MSB slice first.
module result_sram_reader #(
  parameter int ARRAY_SIZE        = 8,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int ADDR_WIDTH        = 6
) (
  input  logic                                      clk,
  input  logic                                      srstn,
  input  logic                                      start,
  input  logic [ADDR_WIDTH:0]                       num_rows,
  output logic                                      busy,
  output logic                                      done,
  output logic [ADDR_WIDTH-1:0]                     sram_raddr,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [OUTPUT_DATA_WIDTH-1:0]              out_data,
  output logic [ADDR_WIDTH-1:0]                     out_row,
  output logic [$clog2(ARRAY_SIZE)-1:0]             out_col,
  output logic                                      out_last
);

  localparam int CW = $clog2(ARRAY_SIZE);
  localparam int W  = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_ROWS =
    (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  localparam logic [CW-1:0] LAST_COL = CW'(ARRAY_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   nrows_q, nrows_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [CW-1:0]         col_q, col_d;
  logic [W-1:0]          buf_q, buf_d;

  logic hs;
  logic last_col;
  logic last_row;

  assign last_col = (col_q == LAST_COL);
  assign last_row = ({1'b0, row_q} ==
                     (nrows_q - (ADDR_WIDTH+1)'(1)));
  assign hs       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q <= S_IDLE;
      nrows_q <= '0;
      row_q   <= '0;
      raddr_q <= '0;
      col_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      nrows_q <= nrows_d;
      row_q   <= row_d;
      raddr_q <= raddr_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    nrows_d = nrows_q;
    row_d   = row_q;
    raddr_d = raddr_q;
    col_d   = col_q;
    buf_d   = buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_rows == '0) begin
            state_d = S_FIN;
          end else begin
            nrows_d = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
            raddr_d = '0;
            row_d   = '0;
            state_d = S_RD;
          end
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        buf_d   = sram_rdata;
        col_d   = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (hs) begin
          buf_d = buf_q << OUTPUT_DATA_WIDTH;
          col_d = last_col ? '0 : col_q + 1'b1;
          if (last_col) begin
            if (last_row) begin
              state_d = S_FIN;
            end else begin
              row_d   = row_q + 1'b1;
              raddr_d = row_q + 1'b1;
              state_d = S_RD;
            end
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign out_valid  = (state_q == S_DRAIN);
  assign out_data   = buf_q[W-1 -: OUTPUT_DATA_WIDTH];
  assign out_row    = row_q;
  assign out_col    = col_q;
  assign out_last   = last_row & last_col & out_valid;
  assign sram_raddr = raddr_q;

endmodule
